// File: rtl/mips_encode.sv
`default_nettype none
// ============================================================================
// Module   : mips_encode
// Purpose  : Symbolic request to 32-bit MIPS word encoder with LI expansion.
// Revision : 1.0 - initial release
// ============================================================================
module mips_encode #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_kind,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] emit_cnt
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    LI_LO = 1'b1
  } state_t;

  localparam logic [5:0]       c_OP_BASE   = 6'h08;
  localparam logic [5:0]       c_OP_ORI    = 6'h0D;
  localparam logic [5:0]       c_OP_LUI    = 6'h0F;
  localparam logic [3:0]       c_K_LUI     = 4'd7;
  localparam logic [3:0]       c_K_SYSCALL = 4'd8;
  localparam logic [3:0]       c_K_NOP     = 4'd9;
  localparam logic [3:0]       c_K_LI      = 4'd10;
  localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_out_valid;
  logic [31:0]      r_out_instr;
  logic             r_err;
  logic [CNT_W-1:0] r_emit_cnt;
  logic [15:0]      r_lo;
  logic [4:0]       r_rt;

  logic [31:0] w_enc_instr;
  logic        w_kind_ok;
  logic        w_li_split;
  logic [15:0] w_hi;
  logic [15:0] w_lo;
  logic        w_accept;
  logic        w_consume;

  assign w_hi      = in_imm[31:16];
  assign w_lo      = in_imm[15:0];
  assign in_ready  = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_out_valid && out_ready;

  always_comb begin
    w_enc_instr = 32'h0000_0000;
    w_kind_ok   = 1'b1;
    w_li_split  = 1'b0;
    if (in_kind <= c_K_LUI) begin
      w_enc_instr = {c_OP_BASE + {2'b00, in_kind},
                     (in_kind == c_K_LUI) ? 5'd0 : in_rs, in_rt, w_lo};
    end else begin
      case (in_kind)
        c_K_SYSCALL: w_enc_instr = 32'h0000_000C;
        c_K_NOP:     w_enc_instr = 32'h0000_0000;
        c_K_LI: begin
          // Upper half zero collapses to a single ORI; otherwise LUI goes first.
          if (w_hi == 16'h0000) begin
            w_enc_instr = {c_OP_ORI, 5'd0, in_rt, w_lo};
          end else begin
            w_enc_instr = {c_OP_LUI, 5'd0, in_rt, w_hi};
            w_li_split  = (w_lo != 16'h0000);
          end
        end
        default:     w_kind_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0000_0000;
      r_err       <= 1'b0;
      r_emit_cnt  <= '0;
      r_lo        <= 16'h0000;
      r_rt        <= 5'd0;
    end else begin
      r_err <= 1'b0;
      if (w_consume) begin
        r_emit_cnt <= r_emit_cnt + c_CNT_ONE;
      end
      case (r_state)
        IDLE: begin
          if (w_accept && w_kind_ok) begin
            r_out_instr <= w_enc_instr;
            r_out_valid <= 1'b1;
            if (w_li_split) begin
              r_state <= LI_LO;
              r_lo    <= w_lo;
              r_rt    <= in_rt;
            end
          end else begin
            r_err <= w_accept;
            if (w_consume) begin
              r_out_valid <= 1'b0;
            end
          end
        end
        LI_LO: begin
          // The LUI word is always on the output here; swap in the ORI once it leaves.
          if (w_consume) begin
            r_out_instr <= {c_OP_ORI, r_rt, r_rt, r_lo};
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign err       = r_err;
  assign busy      = (r_state == LI_LO);
  assign emit_cnt  = r_emit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mips_encode.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_encode
// Purpose  : Directed and randomized checks of mips_encode against a word-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_encode;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_kind;
  logic [4:0]       in_rs;
  logic [4:0]       in_rt;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             err;
  logic             busy;
  logic [CNT_W-1:0] emit_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0]      q[$];
  logic             exp_err;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  mips_encode #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err(err), .busy(busy), .emit_cnt(emit_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_kind  = 4'd0;
    in_rs    = 5'd0;
    in_rt    = 5'd0;
    in_imm   = 32'h0;
  endtask

  task automatic req(input int k, input int rs, input int rt, input logic [31:0] imm);
    in_valid = 1'b1;
    in_kind  = 4'(k);
    in_rs    = 5'(rs);
    in_rt    = 5'(rt);
    in_imm   = imm;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // I-type word built from field arithmetic.
  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int f);
    int unsigned w;
    w = (int'(op) << 26) + (int'(rs) << 21) + (int'(rt) << 16) + (f & 32'hFFFF);
    return 32'(w);
  endfunction

  // Appends every word a request must produce, in emission order.
  task automatic push_words(input int k, input int rs, input int rt, input logic [31:0] imm);
    int hi, lo;
    hi = int'(imm >> 16);
    lo = int'(imm & 32'hFFFF);
    if (k <= 7)       q.push_back(itype(8 + k, (k == 7) ? 0 : rs, rt, lo));
    else if (k == 8)  q.push_back(32'h0000000C);
    else if (k == 9)  q.push_back(32'h00000000);
    else if (k == 10) begin
      if (hi == 0) q.push_back(itype(13, 0, rt, lo));
      else begin
        q.push_back(itype(15, 0, rt, hi));
        if (lo != 0) q.push_back(itype(13, rt, rt, lo));
      end
    end
  endtask

  initial begin
    logic [CNT_W-1:0] cnt0;
    rst = 1'b0;
    out_ready = 1'b0;
    idle_in();
    do_reset();

    // Reset state
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_emit_cnt", 32'(emit_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // ADDIU
    out_ready = 1'b1;
    req(1, 2, 3, 32'h0010);
    #1;
    chk("addiu_in_ready", 32'(in_ready), 32'd1);
    step();
    idle_in();
    chk("addiu_valid", 32'(out_valid), 32'd1);
    chk("addiu_word", out_instr, 32'h24430010);
    step();
    chk("addiu_cnt", 32'(emit_cnt), 32'd1);
    chk("addiu_drain", 32'(out_valid), 32'd0);

    // LI split into LUI/ORI
    req(10, 0, 8, 32'h12345678);
    step();
    idle_in();
    #1;
    chk("li_lui", out_instr, 32'h3C081234);
    chk("li_busy", 32'(busy), 32'd1);
    chk("li_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("li_ori", out_instr, 32'h35085678);
    chk("li_busy_clr", 32'(busy), 32'd0);
    chk("li_ori_valid", 32'(out_valid), 32'd1);
    step();
    chk("li_cnt", 32'(emit_cnt), 32'd3);

    // LI single-word cases, back to back
    req(10, 0, 4, 32'h0000BEEF);
    step();
    chk("li_lo_only", out_instr, 32'h3404BEEF);
    chk("li_lo_busy", 32'(busy), 32'd0);
    req(10, 0, 4, 32'hABCD0000);
    #1;
    chk("li_next_ready", 32'(in_ready), 32'd1);
    step();
    idle_in();
    chk("li_hi_only", out_instr, 32'h3C04ABCD);
    chk("li_hi_busy", 32'(busy), 32'd0);
    step();

    // Backpressure then consume-and-accept
    out_ready = 1'b0;
    req(5, 1, 2, 32'h0000FFFF);
    step();
    req(8, 0, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_word", out_instr, 32'h3422FFFF);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    idle_in();
    chk("bp_syscall", out_instr, 32'h0000000C);
    chk("bp_syscall_valid", 32'(out_valid), 32'd1);
    step();
    chk("bp_cnt", 32'(emit_cnt), 32'd7);

    // Invalid kind then SYSCALL
    cnt0 = emit_cnt;
    req(13, 1, 1, 32'h1);
    step();
    req(8, 0, 0, 32'h0);
    chk("inv_err", 32'(err), 32'd1);
    chk("inv_no_word", 32'(out_valid), 32'd0);
    step();
    idle_in();
    chk("inv_err_clr", 32'(err), 32'd0);
    chk("inv_syscall", out_instr, 32'h0000000C);
    step();
    chk("inv_cnt", 32'(emit_cnt), 32'(cnt0 + 1'b1));

    // Consecutive invalids
    req(11, 0, 0, 32'h0);
    step();
    req(15, 0, 0, 32'h0);
    chk("inv2_err_a", 32'(err), 32'd1);
    step();
    idle_in();
    chk("inv2_err_b", 32'(err), 32'd1);
    step();
    chk("inv2_err_end", 32'(err), 32'd0);

    // Reset in the middle of an LI
    out_ready = 1'b0;
    req(10, 0, 8, 32'h12345678);
    step();
    idle_in();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_busy_clr", 32'(busy), 32'd0);
    chk("mid_cnt", 32'(emit_cnt), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    req(9, 3, 3, 32'hFFFF);
    out_ready = 1'b1;
    step();
    idle_in();
    chk("mid_nop", out_instr, 32'h00000000);
    chk("mid_nop_valid", 32'(out_valid), 32'd1);
    step();

    // Randomized traffic against the word-queue model
    do_reset();
    q.delete();
    exp_err = 1'b0;
    exp_cnt = '0;
    for (int c = 0; c < 600; c++) begin
      logic exp_ready, consume, accept;
      logic [31:0] imm;
      int sel;
      chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("rnd_err", 32'(err), 32'(exp_err));
      chk("rnd_cnt", 32'(emit_cnt), 32'(exp_cnt));
      if (q.size() != 0) chk("rnd_word", out_instr, q[0]);

      sel = int'($urandom_range(0, 3));
      imm = $urandom;
      if (sel == 0) imm[31:16] = 16'h0;
      else if (sel == 1) imm[15:0] = 16'h0;
      req(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), imm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
      chk("rnd_busy", 32'(busy), 32'(q.size() == 2));

      consume = (q.size() != 0) && out_ready;
      accept  = in_valid && exp_ready;
      exp_err = accept && (in_kind >= 4'd11);
      if (consume) begin
        void'(q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
      if (accept) push_words(int'(in_kind), int'(in_rs), int'(in_rt), in_imm);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
